// File: rtl/fc_output_layer.sv
// Fully-connected output layer: 10 class scores, one feature per beat,
// saturating accumulation, one-cycle valid pulse per frame.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   in_valid/ready  beat handshake (ready only while accumulating)
//   in_data         signed activation of current feature
//   in_weights      10 signed weights, class j at [j*W_WIDTH +: W_WIDTH]
//   bias            10 signed biases, class j at [j*DATA_WIDTH +: DATA_WIDTH]
//   layer_out       10 signed scores, held between valid pulses
//   valid           one-cycle pulse when layer_out carries a new frame
//   ovf             some class saturated during the reported frame
module fc_output_layer #(
  parameter int IN_WIDTH   = 8,
  parameter int W_WIDTH    = 8,
  parameter int N_IN       = 64,
  parameter int DATA_WIDTH = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic [10*W_WIDTH-1:0]      in_weights,
  input  logic [10*DATA_WIDTH-1:0]   bias,
  output logic [10*DATA_WIDTH-1:0]   layer_out,
  output logic                       valid,
  output logic                       ovf
);

  localparam int PW = IN_WIDTH + W_WIDTH;
  localparam int SW = DATA_WIDTH + 1;
  localparam int CW = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [CW-1:0] LAST = CW'(N_IN - 1);

  localparam logic [1:0] S_ACC   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                    r_state;
  logic [CW-1:0]                 r_cnt;
  logic                          r_pvld;
  logic signed [PW-1:0]          r_prod [10];
  logic signed [DATA_WIDTH-1:0]  r_acc  [10];
  logic                          r_sticky;

  logic                          w_take;
  logic                          w_last;
  logic signed [PW-1:0]          w_prod [10];
  logic signed [SW-1:0]          w_sum  [10];
  logic signed [DATA_WIDTH-1:0]  w_sat  [10];
  logic [9:0]                    w_clip;

  assign in_ready = (r_state == S_ACC);
  assign w_take   = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);

  // Operands widened to the full product width before multiplying
  always_comb begin
    for (int j = 0; j < 10; j++) begin
      w_prod[j] =
        PW'($signed(in_data)) *
        PW'($signed(in_weights[j*W_WIDTH +: W_WIDTH]));
    end
  end

  // One guard bit: overflow when the two top bits disagree
  always_comb begin
    w_clip = '0;
    for (int j = 0; j < 10; j++) begin
      w_sum[j] = SW'(r_acc[j]) + SW'(r_prod[j]);
      w_clip[j] = w_sum[j][SW-1] ^ w_sum[j][SW-2];
      if (w_clip[j])
        w_sat[j] = w_sum[j][SW-1] ? SAT_MIN : SAT_MAX;
      else
        w_sat[j] = w_sum[j][DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_ACC;
      r_cnt     <= '0;
      r_pvld    <= 1'b0;
      r_sticky  <= 1'b0;
      layer_out <= '0;
      valid     <= 1'b0;
      ovf       <= 1'b0;
      for (int j = 0; j < 10; j++) begin
        r_prod[j] <= '0;
        r_acc[j]  <= bias[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      valid  <= 1'b0;
      r_pvld <= w_take;
      if (w_take) begin
        for (int j = 0; j < 10; j++)
          r_prod[j] <= w_prod[j];
      end

      unique case (1'b1)
        (r_state == S_ACC): begin
          if (w_take) begin
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        (r_state == S_DRAIN): r_state <= S_OUT;
        (r_state == S_OUT):   r_state <= S_ACC;
        default:              r_state <= S_ACC;
      endcase

      // No product is ever pending in OUT, so the reload cannot
      // collide with an accumulation.
      if (r_state == S_OUT) begin
        valid    <= 1'b1;
        ovf      <= r_sticky;
        r_sticky <= 1'b0;
        for (int j = 0; j < 10; j++) begin
          layer_out[j*DATA_WIDTH +: DATA_WIDTH] <= r_acc[j];
          r_acc[j] <= bias[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end else if (r_pvld) begin
        for (int j = 0; j < 10; j++)
          r_acc[j] <= w_sat[j];
        if (|w_clip)
          r_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fc_output_layer.sv
// Directed bench for fc_output_layer: reset, sums, gaps,
// saturation, back-to-back frames, aborted frames.
module tb_fc_output_layer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic signed [7:0] in_data;
  logic [79:0]  in_weights;
  logic [279:0] bias;
  logic [279:0] layer_out;
  logic         valid;
  logic         ovf;

  logic         rst2;
  logic         in_valid2;
  logic         in_ready2;
  logic signed [7:0] in_data2;
  logic [79:0]  in_weights2;
  logic [159:0] bias2;
  logic [159:0] layer_out2;
  logic         valid2;
  logic         ovf2;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fc_output_layer #(
    .IN_WIDTH(8), .W_WIDTH(8), .N_IN(4), .DATA_WIDTH(28)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weights(in_weights),
    .bias(bias), .layer_out(layer_out),
    .valid(valid), .ovf(ovf)
  );

  fc_output_layer #(
    .IN_WIDTH(8), .W_WIDTH(8), .N_IN(2), .DATA_WIDTH(16)
  ) dut2 (
    .clk(clk), .rst(rst2),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .in_weights(in_weights2),
    .bias(bias2), .layer_out(layer_out2),
    .valid(valid2), .ovf(ovf2)
  );

  // Drive one cycle's inputs, return just after the following negedge
  task automatic drive(input logic v, input logic signed [7:0] d,
                       input logic [79:0] w);
    in_valid   = v;
    in_data    = d;
    in_weights = w;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    n_vec++;
    if (layer_out !== 280'd0) begin
      n_bad++; $display("FAIL reset_out: got %h want 0", layer_out);
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [79:0]  w;
    logic [279:0] e;
    for (int j = 0; j < 10; j++) begin
      w[j*8 +: 8]   = 8'(j);
      e[j*28 +: 28] = 28'(4 * j);
    end
    bias = '0;
    rst = 1'b0; drive(1'b0, 8'sd0, w); rst = 1'b1;
    repeat (4) drive(1'b1, 8'sd1, w);
    n_vec++;
    if (valid !== 1'b0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_k0: valid=%b ready=%b want 0 0", valid, in_ready);
    end
    drive(1'b0, 8'sd0, w);
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL basic_k1_valid: got %b want 0", valid);
    end
    drive(1'b0, 8'sd0, w);
    n_vec++;
    if (valid !== 1'b1) begin
      n_bad++; $display("FAIL basic_k2_valid: got %b want 1", valid);
    end
    n_vec++;
    if (layer_out !== e) begin
      n_bad++; $display("FAIL basic_out: got %h want %h", layer_out, e);
    end
    n_vec++;
    if (ovf !== 1'b0) begin
      n_bad++; $display("FAIL basic_ovf: got %b want 0", ovf);
    end
    drive(1'b0, 8'sd0, w);
    n_vec++;
    if (valid !== 1'b0 || layer_out !== e) begin
      n_bad++;
      $display("FAIL basic_hold: valid=%b out=%h want 0 %h",
               valid, layer_out, e);
    end
  endtask

  task automatic test_gaps();
    logic [79:0]  w;
    logic [279:0] e;
    logic [6:0]   pat;
    pat = 7'b1011001;
    for (int j = 0; j < 10; j++) begin
      w[j*8 +: 8]      = 8'(j);
      e[j*28 +: 28]    = 28'(4 * j - 5);
      bias[j*28 +: 28] = -28'sd5;
    end
    rst = 1'b0; drive(1'b0, 8'sd0, w); rst = 1'b1;
    for (int i = 0; i < 7; i++)
      drive(pat[i], pat[i] ? 8'sd1 : 8'sd7, w);
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL gaps_k0_valid: got %b want 0", valid);
    end
    drive(1'b0, 8'sd7, w);
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL gaps_k1_valid: got %b want 0", valid);
    end
    drive(1'b0, 8'sd7, w);
    n_vec++;
    if (valid !== 1'b1 || layer_out !== e) begin
      n_bad++;
      $display("FAIL gaps_out: valid=%b out=%h want 1 %h",
               valid, layer_out, e);
    end
    drive(1'b0, 8'sd0, w);
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL gaps_pulse_len: got %b want 0", valid);
    end
  endtask

  task automatic test_saturation();
    logic [159:0] e;
    in_valid = 1'b0;
    bias2 = '0;
    rst2 = 1'b0; in_valid2 = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = -8'sd128; in_weights2 = {10{8'h80}};
    repeat (2) @(negedge clk);
    in_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    e = {10{16'h7FFF}};
    n_vec++;
    if (valid2 !== 1'b1 || layer_out2 !== e) begin
      n_bad++;
      $display("FAIL sat_out: valid=%b out=%h want 1 %h",
               valid2, layer_out2, e);
    end
    n_vec++;
    if (ovf2 !== 1'b1) begin
      n_bad++; $display("FAIL sat_ovf: got %b want 1", ovf2);
    end
    in_valid2 = 1'b1; in_data2 = 8'sd1; in_weights2 = {10{8'h01}};
    repeat (2) @(negedge clk);
    in_valid2 = 1'b0;
    repeat (2) @(negedge clk);
    e = {10{16'd2}};
    n_vec++;
    if (valid2 !== 1'b1 || layer_out2 !== e || ovf2 !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_clean: valid=%b out=%h ovf=%b want 1 %h 0",
               valid2, layer_out2, ovf2, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [79:0]  w;
    logic [279:0] e1;
    logic [279:0] e2;
    int idx;
    int pulses;
    logic exp_rdy;
    logic exp_vld;
    for (int j = 0; j < 10; j++) begin
      w[j*8 +: 8]    = 8'(j);
      e1[j*28 +: 28] = 28'(10 * j);
      e2[j*28 +: 28] = 28'(26 * j);
    end
    bias = '0;
    rst = 1'b0; drive(1'b0, 8'sd0, w); rst = 1'b1;
    idx = 0;
    pulses = 0;
    for (int c = 0; c < 14; c++) begin
      exp_rdy = ((c % 6) < 4);
      if (c < 12) begin
        n_vec++;
        if (in_ready !== exp_rdy) begin
          n_bad++;
          $display("FAIL b2b_ready c=%0d: got %b want %b",
                   c, in_ready, exp_rdy);
        end
      end
      drive(idx < 8, 8'(idx + 1), w);
      if (exp_rdy && idx < 8) idx++;
      exp_vld = (c == 5 || c == 11);
      n_vec++;
      if (valid !== exp_vld) begin
        n_bad++;
        $display("FAIL b2b_valid c=%0d: got %b want %b", c, valid, exp_vld);
      end
      if (valid === 1'b1) pulses++;
      if (c == 5) begin
        n_vec++;
        if (layer_out !== e1) begin
          n_bad++; $display("FAIL b2b_frame1: got %h want %h", layer_out, e1);
        end
      end
      if (c == 11) begin
        n_vec++;
        if (layer_out !== e2) begin
          n_bad++; $display("FAIL b2b_frame2: got %h want %h", layer_out, e2);
        end
      end
    end
    n_vec++;
    if (pulses != 2) begin
      n_bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
  endtask

  task automatic test_reset_abort();
    logic [79:0]  w;
    logic [79:0]  w1;
    logic [279:0] e;
    for (int j = 0; j < 10; j++) begin
      w[j*8 +: 8]   = 8'(j);
      e[j*28 +: 28] = 28'd8;
    end
    w1 = {10{8'h01}};
    bias = '0;
    rst = 1'b0; drive(1'b0, 8'sd0, w); rst = 1'b1;
    // reset landing on the DRAIN edge must swallow the pulse
    repeat (4) drive(1'b1, 8'sd3, w);
    rst = 1'b0; drive(1'b0, 8'sd0, w); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (valid !== 1'b0) begin
        n_bad++; $display("FAIL drain_rst_valid i=%0d: got %b want 0", i, valid);
      end
      drive(1'b0, 8'sd0, w);
    end
    repeat (2) drive(1'b1, 8'sd5, w);
    rst = 1'b0; drive(1'b0, 8'sd0, w); rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_idle i=%0d: valid=%b ready=%b want 0 1",
                 i, valid, in_ready);
      end
      drive(1'b0, 8'sd0, w);
    end
    repeat (4) drive(1'b1, 8'sd2, w1);
    drive(1'b0, 8'sd0, w1);
    n_vec++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL abort_k1_valid: got %b want 0", valid);
    end
    drive(1'b0, 8'sd0, w1);
    n_vec++;
    if (valid !== 1'b1 || layer_out !== e) begin
      n_bad++;
      $display("FAIL abort_out: valid=%b out=%h want 1 %h",
               valid, layer_out, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_weights = '0;
    bias = '0;
    rst2 = 1'b0;
    in_valid2 = 1'b0;
    in_data2 = '0;
    in_weights2 = '0;
    bias2 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_saturation();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_output_layer.md
FC_OUTPUT_LAYER -- requirements
Module: fc_output_layer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8, signed input activation width.
REQ-002 SHALL have parameter W_WIDTH, default 8, signed weight width.
REQ-003 SHALL have parameter N_IN, default 64, number of input features per frame (≥2).
REQ-004 SHALL have parameter DATA_WIDTH, default 28, signed accumulator/output width per class.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  input beat present.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port in_data  input  IN_WIDTH  signed activation of current feature.
REQ-010 SHALL have port in_weights  input  10*W_WIDTH  signed weights of current feature; class j at [j*W_WIDTH +: W_WIDTH].
REQ-011 SHALL have port bias  input  10*DATA_WIDTH  signed per-class bias, static during a frame; class j at [j*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port layer_out  output  10*DATA_WIDTH  signed class scores; class j at [j*DATA_WIDTH +: DATA_WIDTH] (class 0 in LSBs), feeds comparator layer_out.
REQ-013 SHALL have port valid  output  1  one-cycle pulse: layer_out updated with a new frame, feeds comparator valid.
REQ-014 SHALL have port ovf  output  1  at least one class saturated during the reported frame.

Function
REQ-015 Beat accepted on a posedge where in_valid=1 and in_ready=1; no other beat consumed.
REQ-016 States: ACC, DRAIN, OUT; in_ready=1 only in ACC.
REQ-017 ACC: beat counter cnt (0..N_IN-1) increments per accepted beat; beat accepted with cnt=N_IN-1 -> DRAIN, cnt<=0.
REQ-018 Stage 1: on acceptance, register 10 signed products in_data*weight_j (IN_WIDTH+W_WIDTH bits) plus product-valid flag.
REQ-019 Stage 2: cycle after stage 1, acc_j <= sat(acc_j + sign-extended product_j).
REQ-020 sat(): result clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] on signed overflow; per-frame sticky flag set on any clamp.
REQ-021 DRAIN lasts exactly 1 cycle (last product accumulated) -> OUT.
REQ-022 OUT lasts exactly 1 cycle: on its edge layer_out<=acc, ovf<=sticky flag, valid<=1; acc_j<=sign-extended bias_j, sticky<=0, state->ACC.
REQ-023 Latency: last beat accepted at edge k -> valid high in cycle after edge k+2, for exactly one cycle.
REQ-024 Throughput: next frame's first beat accepted no earlier than edge k+3; in_valid held during DRAIN/OUT is stalled, not dropped.
REQ-025 Gaps (in_valid=0) inside a frame SHALL not alter results; cnt and acc hold.
REQ-026 layer_out and ovf SHALL hold between valid pulses (comparator samples continuously).
REQ-027 At frame start acc_j = bias_j sign-extended; final layer_out_j = sat-accumulated bias_j + Σ in_data·w_j.

Reset
REQ-028 With rst=0 at a posedge: state=ACC, cnt=0, product-valid=0, acc_j<=bias_j, sticky=0, layer_out=0, valid=0, ovf=0; in_ready=1 from first cycle after reset.
REQ-029 Reset mid-frame SHALL discard partial frame, emit no valid; next frame starts at cnt=0.
REQ-030 Reset during DRAIN or OUT SHALL suppress the pending valid pulse.

Verification (bench N_IN=4 unless stated)
REQ-031 Reset: rst=0 two cycles -> in_ready=1, valid=0, layer_out=0, ovf=0.
REQ-032 bias=0, in_data=1 ×4 back-to-back, w_j=j -> layer_out_j=4j, ovf=0, valid high one cycle, 2 cycles after last-beat edge.
REQ-033 Same frame with in_valid gapped (1,0,0,1,1,0,1) and bias_j=-5 -> layer_out_j=4j-5, identical timing relative to last beat.
REQ-034 DATA_WIDTH=16, N_IN=2, bias=0, in_data=-128, all w=-128 -> every layer_out_j=32767, ovf=1; next clean frame -> ovf=0.
REQ-035 in_valid held high continuously across two frames -> in_ready=0 in DRAIN/OUT, exactly 8 beats consumed, two valid pulses, correct sums.
REQ-036 rst=0 after 2 beats, then full frame of in_data=2, w_j=1 -> no valid for aborted frame, layer_out_j=8.
